// File: rtl/fifo_threshold.sv
// fifo_threshold: DEPTH-entry synchronous FIFO with live almost-full/almost-empty
// thresholds, gated by a one-hot controller state.
//
// Ports:
//   clk            - single clock, all state changes on the rising edge
//   reset_L        - asynchronous active-low reset
//   state          - one-hot controller state (RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000)
//   sup_Threshold  - almost-full threshold (0 disables almost_full)
//   inf_Threshold  - almost-empty threshold
//   push, data_in  - write request and data
//   pop            - read request
//   data_out       - registered read data, valid one cycle after an accepted pop
//   valid_out      - data_out qualifier, high only for the cycle after an accepted pop
//   count          - occupancy 0..DEPTH
//   empty, full, almost_full, almost_empty - combinational flags from registered count
//   error          - sticky overflow/underflow flag
module fifo_threshold #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [3:0]       state,
  input  logic [PtrW-1:0]  sup_Threshold,
  input  logic [PtrW-1:0]  inf_Threshold,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             error
);

  localparam logic [3:0] StReset  = 4'b0001;
  localparam logic [3:0] StInit   = 4'b0010;
  localparam logic [3:0] StIdle   = 4'b0100;
  localparam logic [3:0] StActive = 4'b1000;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic [CntW-1:0]  count_q;
  logic             operating, flushing;
  logic             pop_ok, push_ok, err_set;

  // Any non-one-hot state value is neither operating nor flushing: everything holds.
  assign operating = (state == StIdle) || (state == StActive);
  assign flushing  = (state == StReset) || (state == StInit);

  assign empty        = (count_q == '0);
  assign full         = (count_q == CntW'(DEPTH));
  assign almost_full  = (sup_Threshold != '0) && (count_q >= CntW'(sup_Threshold));
  assign almost_empty = (count_q <= CntW'(inf_Threshold));
  assign count        = count_q;

  assign pop_ok  = operating && pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign push_ok = operating && push && (!full || pop_ok);
  assign err_set = operating && ((push && full && !pop_ok) || (pop && empty));

  assign wr_ptr_nxt = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_nxt = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

  // Storage is not reset; flushing only clears pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else if (flushing) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_nxt;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_nxt;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (err_set) begin
        error <= 1'b1;
      end
    end
  end

endmodule
